// File: rtl/sram_bus_slave.sv
// Bus-to-asynchronous-SRAM bridge: latches each master request and sequences ce_n/oe_n/we_n with a one-cycle ack.
// Optional single-entry read cache is enabled by defining SRAM_BUS_READ_CACHE_EN.
module sram_bus_slave #(
  parameter int ADDR_W  = 16,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [15:0]       i_addr,
  input  logic [7:0]        i_dat,
  output logic [7:0]        o_dat,
  input  logic              i_cs,
  input  logic              i_we,
  output logic              o_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [7:0]        o_sram_dat,
  output logic              o_sram_dat_oe,
  input  logic [7:0]        i_sram_dat,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    ACK      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         wdat_q, wdat_d;
  logic [7:0]         rdat_q, rdat_d;
  logic               ack_q, ack_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               dat_oe_q, dat_oe_d;

`ifdef SRAM_BUS_READ_CACHE_EN
  logic               cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0]  cache_tag_q, cache_tag_d;
  logic [7:0]         cache_data_q, cache_data_d;
  logic               cache_match_s;

  assign cache_match_s = cache_valid_q && (cache_tag_q == i_addr[ADDR_W-1:0]);
`endif

  // Next-state, request latching and read capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
`ifdef SRAM_BUS_READ_CACHE_EN
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_cs) begin
          addr_d = i_addr[ADDR_W-1:0];
          wdat_d = i_dat;
          if (i_we) begin
            state_d = WR_SETUP;
`ifdef SRAM_BUS_READ_CACHE_EN
            if (cache_match_s) begin
              cache_data_d = i_dat;
            end else begin
              cache_data_d = cache_data_q;
            end
`endif
          end else begin
`ifdef SRAM_BUS_READ_CACHE_EN
            if (cache_match_s) begin
              state_d = ACK;
              rdat_d  = cache_data_q;
            end else begin
              state_d = READ;
              cnt_d   = CNT_W'(RD_WAIT - 1);
            end
`else
            state_d = READ;
            cnt_d   = CNT_W'(RD_WAIT - 1);
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (cnt_q == 8'd0) begin
          rdat_d  = i_sram_dat;
          state_d = ACK;
`ifdef SRAM_BUS_READ_CACHE_EN
          cache_valid_d = 1'b1;
          cache_tag_d   = addr_q;
          cache_data_d  = i_sram_dat;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_W'(WR_WAIT - 1);
      end
      WR_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WR_HOLD: state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up with the state they belong to.
  always_comb begin
    ack_d    = 1'b0;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    dat_oe_d = 1'b0;
    case (state_d)
      READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d   = 1'b0;
        dat_oe_d = 1'b1;
      end
      WR_PULSE: begin
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        dat_oe_d = 1'b1;
      end
      ACK:     ack_d = 1'b1;
      default: ack_d = 1'b0;
    endcase
  end

  // State and output registers; reset aborts any access on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      wdat_q   <= 8'h00;
      rdat_q   <= 8'h00;
      ack_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dat_oe_q <= dat_oe_d;
    end
  end

`ifdef SRAM_BUS_READ_CACHE_EN
  // Read cache entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= 8'h00;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end
`endif

  assign o_dat         = rdat_q;
  assign o_ack         = ack_q;
  assign o_sram_addr   = addr_q;
  assign o_sram_dat    = wdat_q;
  assign o_sram_dat_oe = dat_oe_q;
  assign o_sram_ce_n   = ce_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_bus_slave.sv
// Directed, cycle-exact bench for sram_bus_slave with a behavioural asynchronous SRAM.
module tb_sram_bus_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdat;
  logic [7:0]  rdat;
  logic        cs;
  logic        we;
  logic        ack;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdat;
  logic        sram_dat_oe;
  logic [7:0]  sram_rdat;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  sram_bus_slave #(.ADDR_W(16), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat), .o_dat(rdat),
    .i_cs(cs), .i_we(we), .o_ack(ack), .o_sram_addr(sram_addr),
    .o_sram_dat(sram_wdat), .o_sram_dat_oe(sram_dat_oe), .i_sram_dat(sram_rdat),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n)
  );

  assign sram_rdat = mem[sram_addr[7:0]];

  always @(posedge clk) begin
    if (!we_n && !ce_n && sram_dat_oe) mem[sram_addr[7:0]] <= sram_wdat;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [15:0] a, input logic [7:0] d);
    cs = 1'b1; we = w; addr = a; wdat = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (ack !== 1'b0)        begin n_bad++; $display("FAIL rst_ack got %b exp 0", ack); end
    n_cmp++; if (rdat !== 8'h00)      begin n_bad++; $display("FAIL rst_dat got %h exp 00", rdat); end
    n_cmp++; if (ce_n !== 1'b1)       begin n_bad++; $display("FAIL rst_ce_n got %b exp 1", ce_n); end
    n_cmp++; if (oe_n !== 1'b1)       begin n_bad++; $display("FAIL rst_oe_n got %b exp 1", oe_n); end
    n_cmp++; if (we_n !== 1'b1)       begin n_bad++; $display("FAIL rst_we_n got %b exp 1", we_n); end
    n_cmp++; if (sram_dat_oe !== 1'b0) begin n_bad++; $display("FAIL rst_dat_oe got %b exp 0", sram_dat_oe); end
    n_cmp++; if (sram_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_addr got %h exp 0000", sram_addr); end
    n_cmp++; if (sram_wdat !== 8'h00) begin n_bad++; $display("FAIL rst_sram_dat got %h exp 00", sram_wdat); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    start(1'b0, 16'h0010, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (oe_n !== ((k <= 2) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL read_oe_n cyc%0d got %b", k, oe_n); end
      n_cmp++; if (ce_n !== ((k <= 2) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL read_ce_n cyc%0d got %b", k, ce_n); end
      n_cmp++; if (ack !== ((k == 3) ? 1'b1 : 1'b0))  begin n_bad++; $display("FAIL read_ack cyc%0d got %b", k, ack); end
      n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL read_we_n cyc%0d got %b exp 1", k, we_n); end
      if (k == 1) begin
        n_cmp++; if (sram_addr !== 16'h0010) begin n_bad++; $display("FAIL read_addr got %h exp 0010", sram_addr); end
      end
      if (k == 3) begin
        n_cmp++; if (rdat !== 8'hA5) begin n_bad++; $display("FAIL read_dat got %h exp A5", rdat); end
        cs = 1'b0;
      end
    end
  endtask

  task automatic test_write();
    start(1'b1, 16'h0020, 8'h3C);
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++; if (we_n !== ((k == 2 || k == 3) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL wr_we_n cyc%0d got %b", k, we_n); end
      n_cmp++; if (sram_dat_oe !== ((k <= 4) ? 1'b1 : 1'b0))    begin n_bad++; $display("FAIL wr_dat_oe cyc%0d got %b", k, sram_dat_oe); end
      n_cmp++; if (ack !== ((k == 5) ? 1'b1 : 1'b0))            begin n_bad++; $display("FAIL wr_ack cyc%0d got %b", k, ack); end
      n_cmp++; if (oe_n !== 1'b1) begin n_bad++; $display("FAIL wr_oe_n cyc%0d got %b exp 1", k, oe_n); end
      if (k == 1) begin
        n_cmp++; if (sram_wdat !== 8'h3C) begin n_bad++; $display("FAIL wr_sram_dat got %h exp 3C", sram_wdat); end
      end
      if (k == 5) begin
        n_cmp++; if (rdat !== 8'hA5) begin n_bad++; $display("FAIL wr_keeps_o_dat got %h exp A5", rdat); end
        cs = 1'b0;
      end
    end
    start(1'b0, 16'h0020, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (ack !== ((k == 3) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL rdback_ack cyc%0d got %b", k, ack); end
      if (k == 3) begin
        n_cmp++; if (rdat !== 8'h3C) begin n_bad++; $display("FAIL rdback_dat got %h exp 3C", rdat); end
        cs = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    start(1'b0, 16'h0030, 8'h00);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (ack === 1'b1) acks++;
      if (k == 3) begin
        n_cmp++; if (ack !== 1'b1 || rdat !== 8'h5A) begin n_bad++; $display("FAIL b2b_first ack %b dat %h exp 1/5A", ack, rdat); end
        addr = 16'h0031;
      end
      if (k == 5) begin
        n_cmp++; if (sram_addr !== 16'h0031 || oe_n !== 1'b0) begin n_bad++; $display("FAIL b2b_second_start addr %h oe_n %b", sram_addr, oe_n); end
      end
      if (k == 7) begin
        n_cmp++; if (ack !== 1'b1 || rdat !== 8'hC3) begin n_bad++; $display("FAIL b2b_second ack %b dat %h exp 1/C3", ack, rdat); end
        cs = 1'b0;
      end
    end
    n_cmp++; if (acks != 2) begin n_bad++; $display("FAIL b2b_ack_count got %0d exp 2", acks); end
  endtask

  task automatic test_mid_read_change();
    start(1'b0, 16'h0050, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 1) begin addr = 16'h0060; we = 1'b1; wdat = 8'hFF; end
      if (k <= 3) begin
        n_cmp++; if (sram_addr !== 16'h0050) begin n_bad++; $display("FAIL mid_addr cyc%0d got %h exp 0050", k, sram_addr); end
      end
      n_cmp++; if (we_n !== 1'b1 || sram_dat_oe !== 1'b0) begin n_bad++; $display("FAIL mid_no_write cyc%0d we_n %b oe %b", k, we_n, sram_dat_oe); end
      n_cmp++; if (ack !== ((k == 3) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL mid_ack cyc%0d got %b", k, ack); end
      if (k == 3) begin
        n_cmp++; if (rdat !== 8'h11) begin n_bad++; $display("FAIL mid_dat got %h exp 11", rdat); end
        cs = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int acks = 0;
    start(1'b1, 16'h0070, 8'h99);
    step(); step();
    n_cmp++; if (we_n !== 1'b0) begin n_bad++; $display("FAIL rmw_in_pulse we_n got %b exp 0", we_n); end
    rst = 1'b1;
    step();
    n_cmp++; if (we_n !== 1'b1 || sram_dat_oe !== 1'b0 || ack !== 1'b0 || ce_n !== 1'b1)
      begin n_bad++; $display("FAIL rmw_abort we_n %b oe %b ack %b ce_n %b exp 1/0/0/1", we_n, sram_dat_oe, ack, ce_n); end
    rst = 1'b0; cs = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack === 1'b1) acks++;
    end
    n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL rmw_stray_ack got %0d exp 0", acks); end
    start(1'b0, 16'h0010, 8'h00);
    for (int k = 1; k <= 4; k++) begin
      step();
      n_cmp++; if (ack !== ((k == 3) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL rmw_idle_ack cyc%0d got %b", k, ack); end
      if (k == 3) begin
        n_cmp++; if (rdat !== 8'hA5) begin n_bad++; $display("FAIL rmw_idle_dat got %h exp A5", rdat); end
        cs = 1'b0;
      end
    end
  endtask

  task automatic test_repeat_read();
`ifdef SRAM_BUS_READ_CACHE_EN
    int hit_cyc = 1;
`else
    int hit_cyc = 3;
`endif
    for (int r = 0; r < 2; r++) begin
      start(1'b0, 16'h0040, 8'h00);
      for (int k = 1; k <= 4; k++) begin
        step();
        if (r == 1 && k == 1 && hit_cyc == 1) begin
          n_cmp++; if (oe_n !== 1'b1 || ce_n !== 1'b1) begin n_bad++; $display("FAIL hit_strobes oe_n %b ce_n %b exp 1/1", oe_n, ce_n); end
        end
        n_cmp++; if (ack !== ((k == ((r == 0) ? 3 : hit_cyc)) ? 1'b1 : 1'b0)) begin n_bad++; $display("FAIL rep_ack rd%0d cyc%0d got %b", r, k, ack); end
        if (ack === 1'b1) begin
          n_cmp++; if (rdat !== 8'hB4) begin n_bad++; $display("FAIL rep_dat rd%0d got %h exp B4", r, rdat); end
          cs = 1'b0;
        end
      end
    end
`ifdef SRAM_BUS_READ_CACHE_EN
    start(1'b1, 16'h0040, 8'h77);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) cs = 1'b0;
    end
    start(1'b0, 16'h0040, 8'h00);
    step();
    n_cmp++; if (ack !== 1'b1 || rdat !== 8'h77 || oe_n !== 1'b1) begin n_bad++; $display("FAIL cache_wt ack %b dat %h oe_n %b exp 1/77/1", ack, rdat, oe_n); end
    cs = 1'b0;
    step();
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h30] = 8'h5A;
    mem[8'h31] = 8'hC3;
    mem[8'h40] = 8'hB4;
    mem[8'h50] = 8'h11;
    rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 16'h0000; wdat = 8'h00;
    step();
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_mid_read_change();
    test_reset_mid_write();
    test_repeat_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
